// File: rtl/note_tone_player.sv
// PWM tone generator: plays a one-hot note as a square wave at a chosen volume, for a
// fixed number of milliseconds or until stopped. Drives the audio PWM pin and the amp enable.
module note_tone_player #(
  parameter int MS_DIV     = 100_000,
  parameter int DUR_BITS   = 16,
  parameter int TONE_SHIFT = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [6:0]          note_in,
  input  logic [2:0]          vol_in,
  input  logic [DUR_BITS-1:0] dur_ms_in,
  input  logic                stop_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                aud_pwm,
  output logic                aud_sd,
  output logic [1:0]          state_dbg_out
);

  localparam int HP_W = 18;
  localparam int MS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          vol_q, vol_d;
  logic [DUR_BITS-1:0] rem_q, rem_d;
  logic                timed_q, timed_d;
  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          vol_step;
  logic [7:0]          duty;

  // Half-period in clocks for the lowest set note bit; never returns 0 so the wrap compare stays valid.
  function automatic logic [HP_W-1:0] half_period(input logic [6:0] note);
    logic [HP_W-1:0] hp;
    if (note[0])      hp = 18'd191110;
    else if (note[1]) hp = 18'd170265;
    else if (note[2]) hp = 18'd151686;
    else if (note[3]) hp = 18'd143172;
    else if (note[4]) hp = 18'd127551;
    else if (note[5]) hp = 18'd113636;
    else              hp = 18'd101239;
    hp = hp >> TONE_SHIFT;
    if (hp == '0) hp = 18'd1;
    return hp;
  endfunction

  // start_in is a single-cycle request honoured only in IDLE with a non-zero note;
  // stop_in is level-sampled and only acts in PLAY. There is no back-pressure.
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    hp_cnt_d  = hp_cnt_q;
    phase_d   = phase_q;
    vol_d     = vol_q;
    rem_d     = rem_q;
    timed_d   = timed_q;
    ms_cnt_d  = ms_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_in && (note_in != 7'd0)) begin
          state_d   = S_PLAY;
          hp_d      = half_period(note_in);
          hp_cnt_d  = '0;
          phase_d   = 1'b1;
          vol_d     = vol_in;
          rem_d     = dur_ms_in;
          timed_d   = (dur_ms_in != '0);
          ms_cnt_d  = '0;
          pwm_cnt_d = '0;
        end
      end
      S_PLAY: begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (hp_cnt_q == hp_q - HP_W'(1)) begin
          hp_cnt_d = '0;
          phase_d  = ~phase_q;
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
        if (timed_q) begin
          if (ms_cnt_q == MS_LAST) begin
            ms_cnt_d = '0;
            if (rem_q != '0) rem_d = rem_q - DUR_BITS'(1);
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
        // Timeout and stop collapse into the same transition, so only one FINISH results.
        if (stop_in || (timed_q && (rem_q == '0))) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      hp_q      <= '0;
      hp_cnt_q  <= '0;
      phase_q   <= 1'b0;
      vol_q     <= '0;
      rem_q     <= '0;
      timed_q   <= 1'b0;
      ms_cnt_q  <= '0;
      pwm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      hp_cnt_q  <= hp_cnt_d;
      phase_q   <= phase_d;
      vol_q     <= vol_d;
      rem_q     <= rem_d;
      timed_q   <= timed_d;
      ms_cnt_q  <= ms_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Duty swings symmetrically around midscale; vol=0 leaves a silent 50% carrier.
  always_comb begin
    vol_step      = {1'b0, vol_q, 4'b0000};
    duty          = phase_q ? (8'd128 + vol_step) : (8'd128 - vol_step);
    busy_out      = (state_q == S_PLAY);
    aud_sd        = (state_q == S_PLAY);
    done_out      = (state_q == S_FINISH);
    aud_pwm       = (state_q == S_PLAY) && (pwm_cnt_q < duty);
    state_dbg_out = state_q;
  end

endmodule

// File: tb/tb_note_tone_player.sv
// Directed bench for note_tone_player with MS_DIV=10 and TONE_SHIFT=10
// (A4 half-period 110, D4 166, C4 186 clocks).
module tb_note_tone_player;

  localparam int MS_DIV     = 10;
  localparam int DUR_BITS   = 16;
  localparam int TONE_SHIFT = 10;
  localparam int HP_C4 = 186;
  localparam int HP_D4 = 166;
  localparam int HP_A4 = 110;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic                start_in = 1'b0;
  logic [6:0]          note_in = '0;
  logic [2:0]          vol_in = '0;
  logic [DUR_BITS-1:0] dur_ms_in = '0;
  logic                stop_in = 1'b0;
  logic                busy_out, done_out, aud_pwm, aud_sd;
  logic [1:0]          state_dbg_out;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  note_tone_player #(.MS_DIV(MS_DIV), .DUR_BITS(DUR_BITS), .TONE_SHIFT(TONE_SHIFT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .note_in(note_in),
    .vol_in(vol_in), .dur_ms_in(dur_ms_in), .stop_in(stop_in),
    .busy_out(busy_out), .done_out(done_out), .aud_pwm(aud_pwm), .aud_sd(aud_sd),
    .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (done_out) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_tone(input logic [6:0] note, input logic [2:0] vol, input logic [DUR_BITS-1:0] dur);
    start_in = 1'b1; note_in = note; vol_in = vol; dur_ms_in = dur;
    step();
    start_in = 1'b0; note_in = '0;
  endtask

  // Expected PWM bit i cycles into PLAY: phase flips every hp cycles starting high,
  // pwm counter starts at 0, duty = 128 +/- 16*vol.
  function automatic logic exp_pwm(input int i, input int hp, input int vol);
    int cnt, duty;
    cnt  = i % 256;
    duty = (((i / hp) % 2) == 0) ? 128 + 16 * vol : 128 - 16 * vol;
    return (cnt < duty);
  endfunction

  task automatic test_reset();
    int d0;
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy_out); end
    total++; if (aud_sd !== 1'b0) begin bad++; $display("FAIL rst_sd: got %b expected 0", aud_sd); end
    total++; if (aud_pwm !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %b expected 0", aud_pwm); end
    total++; if (done_out !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done_out); end
    rst_in = 1'b0;
    step();
    total++; if (state_dbg_out !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d expected 0", state_dbg_out); end
    start_tone(7'b0100000, 3'd7, 16'd0);
    repeat (4) step();
    total++; if ({busy_out, aud_sd, aud_pwm} !== 3'b111) begin bad++; $display("FAIL midrun_active: got %b expected 111", {busy_out, aud_sd, aud_pwm}); end
    d0 = done_cnt;
    #2 rst_in = 1'b1;
    #1;
    total++; if ({busy_out, aud_sd, aud_pwm} !== 3'b000) begin bad++; $display("FAIL async_rst: got %b expected 000", {busy_out, aud_sd, aud_pwm}); end
    repeat (3) step();
    rst_in = 1'b0;
    repeat (20) step();
    total++; if (done_cnt !== d0 || busy_out !== 1'b0) begin bad++; $display("FAIL rst_no_done: got done=%0d busy=%b expected done=%0d busy=0", done_cnt - d0 + d0, busy_out, d0); end
  endtask

  task automatic test_a4_timed();
    int d0, n, mism;
    d0 = done_cnt; n = 0; mism = 0;
    start_tone(7'b0100000, 3'd7, 16'd3);
    while (busy_out && n < 100) begin
      if (aud_pwm !== exp_pwm(n, HP_A4, 7)) mism++;
      n++;
      step();
    end
    total++; if (n < 29 || n > 31) begin bad++; $display("FAIL a4_busy_len: got %0d expected 31 (+/-1)", n); end
    total++; if (mism != 0) begin bad++; $display("FAIL a4_timed_pwm: got %0d bad cycles expected 0", mism); end
    total++; if (done_out !== 1'b1) begin bad++; $display("FAIL a4_done_pulse: got %b expected 1", done_out); end
    step();
    total++; if (done_out !== 1'b0 || state_dbg_out !== 2'd0) begin bad++; $display("FAIL a4_done_end: got done=%b state=%0d expected 0/0", done_out, state_dbg_out); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL a4_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_a4_phase();
    int mism, first_fall, rise;
    mism = 0; first_fall = -1; rise = -1;
    start_tone(7'b0100000, 3'd7, 16'd0);
    for (int i = 0; i < 660; i++) begin
      if (aud_pwm !== exp_pwm(i, HP_A4, 7)) mism++;
      if (aud_pwm === 1'b0 && first_fall < 0) first_fall = i;
      if (aud_pwm === 1'b1 && first_fall >= 0 && rise < 0) rise = i;
      step();
    end
    total++; if (first_fall != 110) begin bad++; $display("FAIL a4_first_toggle: got %0d expected 110", first_fall); end
    total++; if (rise != 220) begin bad++; $display("FAIL a4_second_toggle: got %0d expected 220", rise); end
    total++; if (mism != 0) begin bad++; $display("FAIL a4_duty_model: got %0d bad cycles expected 0", mism); end
    stop_in = 1'b1; step(); stop_in = 1'b0;
    total++; if (done_out !== 1'b1 || busy_out !== 1'b0) begin bad++; $display("FAIL a4_stop: got done=%b busy=%b expected 1/0", done_out, busy_out); end
    step();
  endtask

  task automatic test_d4_lowest_bit();
    int mism, first_fall;
    mism = 0; first_fall = -1;
    start_tone(7'b0000110, 3'd5, 16'd0);
    for (int i = 0; i < 500; i++) begin
      if (aud_pwm !== exp_pwm(i, HP_D4, 5)) mism++;
      if (aud_pwm === 1'b0 && first_fall < 0) first_fall = i;
      step();
    end
    total++; if (first_fall != 166) begin bad++; $display("FAIL d4_toggle: got %0d expected 166", first_fall); end
    total++; if (mism != 0) begin bad++; $display("FAIL d4_duty_model: got %0d bad cycles expected 0", mism); end
    stop_in = 1'b1; step(); stop_in = 1'b0;
    step();
  endtask

  task automatic test_idle_ignore();
    int d0, busy_seen, highs, mism;
    d0 = done_cnt; busy_seen = 0; highs = 0; mism = 0;
    start_in = 1'b1; note_in = 7'd0; vol_in = 3'd3; dur_ms_in = 16'd2;
    step();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy_out !== 1'b0) busy_seen++;
      step();
    end
    stop_in = 1'b1; step(); stop_in = 1'b0; step();
    total++; if (busy_seen != 0 || state_dbg_out !== 2'd0) begin bad++; $display("FAIL zero_note: got busy_cycles=%0d state=%0d expected 0/0", busy_seen, state_dbg_out); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL idle_no_done: got %0d expected %0d", done_cnt, d0); end
    start_tone(7'b0000001, 3'd0, 16'd0);
    for (int i = 0; i < 512; i++) begin
      if (aud_pwm === 1'b1) highs++;
      if (aud_pwm !== exp_pwm(i, HP_C4, 0)) mism++;
      step();
    end
    total++; if (highs != 256) begin bad++; $display("FAIL vol0_duty: got %0d expected 256", highs); end
    total++; if (mism != 0) begin bad++; $display("FAIL vol0_model: got %0d bad cycles expected 0", mism); end
    stop_in = 1'b1; step(); stop_in = 1'b0;
    step();
  endtask

  task automatic test_no_timeout();
    int d0, idle_seen;
    d0 = done_cnt; idle_seen = 0;
    start_tone(7'b0000001, 3'd3, 16'd0);
    for (int i = 0; i < 10000; i++) begin
      if (busy_out !== 1'b1) idle_seen++;
      step();
    end
    total++; if (idle_seen != 0 || busy_out !== 1'b1) begin bad++; $display("FAIL dur0_busy: got idle_cycles=%0d busy=%b expected 0/1", idle_seen, busy_out); end
    stop_in = 1'b1; step(); stop_in = 1'b0;
    total++; if ({done_out, busy_out, aud_sd, aud_pwm} !== 4'b1000) begin bad++; $display("FAIL dur0_stop: got %b expected 1000", {done_out, busy_out, aud_sd, aud_pwm}); end
    step();
    total++; if (done_out !== 1'b0 || done_cnt - d0 != 1) begin bad++; $display("FAIL dur0_single_done: got done=%b count=%0d expected 0/1", done_out, done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int d0, n, mism;
    d0 = done_cnt; n = 0; mism = 0;
    start_tone(7'b0100000, 3'd7, 16'd3);
    while (busy_out && n < 100) begin
      if (aud_pwm !== exp_pwm(n, HP_A4, 7)) mism++;
      start_in = (n == 5);
      if (n == 5) begin note_in = 7'b1000000; vol_in = 3'd0; dur_ms_in = 16'd1; end
      stop_in = (n == 30);
      n++;
      step();
    end
    start_in = 1'b0; stop_in = 1'b0; note_in = '0;
    total++; if (n < 29 || n > 31) begin bad++; $display("FAIL restart_ignored_len: got %0d expected 31 (+/-1)", n); end
    total++; if (mism != 0) begin bad++; $display("FAIL restart_ignored_pwm: got %0d bad cycles expected 0", mism); end
    total++; if (done_out !== 1'b1) begin bad++; $display("FAIL stop_on_timeout_pulse: got %b expected 1", done_out); end
    repeat (5) step();
    total++; if (done_cnt - d0 != 1 || busy_out !== 1'b0) begin bad++; $display("FAIL stop_on_timeout_single: got count=%0d busy=%b expected 1/0", done_cnt - d0, busy_out); end
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_a4_timed();
    test_a4_phase();
    test_d4_lowest_bit();
    test_idle_ignore();
    test_no_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
